// File: rtl/reg_write_ctrl.sv
// Write-port arbiter for the general-register file: grants requester A or B round-robin
// and drives a registered one-hot WE/SEL/DATA, splitting AX..BX word writes into two byte beats.
module reg_write_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        a_req,
    input  logic        a_w,
    input  logic [2:0]  a_reg,
    input  logic [15:0] a_data,
    output logic        a_ack,
    input  logic        b_req,
    input  logic        b_w,
    input  logic [2:0]  b_reg,
    input  logic [15:0] b_data,
    output logic        b_ack,
    output logic [11:0] WE,
    output logic        SEL,
    output logic [15:0] DATA,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, ISSUE_HI} state_t;

    state_t      state_q, state_d;
    logic        ptr_b_q, ptr_b_d;
    logic        owner_b_q, owner_b_d;
    logic        w_q, w_d;
    logic [2:0]  reg_q, reg_d;
    logic [15:0] data_q, data_d;
    logic [11:0] we_q, we_d;
    logic        sel_q, sel_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic        busy_q, busy_d;
    logic        gnt_a, gnt_b, last;

    // AX..BX word writes go through the shared byte mux, so they need two beats.
    function automatic logic is_split(input logic w, input logic [2:0] r);
        return w & ~r[2];
    endfunction

    function automatic logic [11:0] first_we(input logic w, input logic [2:0] r);
        if (w && r[2])
            return 12'b1 << (3'd7 - r);
        return 12'b1 << (4'd11 - {1'b0, r});
    endfunction

    function automatic logic [11:0] hi_we(input logic [2:0] r);
        return 12'b1 << (3'd7 - r);
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_b_d   = ptr_b_q;
        owner_b_d = owner_b_q;
        w_d       = w_q;
        reg_d     = reg_q;
        data_d    = data_q;
        we_d      = '0;
        sel_d     = 1'b0;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        busy_d    = 1'b0;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        last      = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_a = a_req & (~b_req | ptr_b_q);
                gnt_b = b_req & ~gnt_a;
            end
            ISSUE: begin
                if (is_split(w_q, reg_q)) begin
                    state_d = ISSUE_HI;
                    we_d    = hi_we(reg_q);
                    sel_d   = 1'b1;
                    a_ack_d = ~owner_b_q;
                    b_ack_d = owner_b_q;
                    busy_d  = 1'b1;
                end else begin
                    last = 1'b1;
                end
            end
            ISSUE_HI: last = 1'b1;
            default:  state_d = IDLE;
        endcase

        // The owner still holds req in its final cycle, so only the other side may follow on.
        if (last) begin
            state_d = IDLE;
            gnt_a   = owner_b_q & a_req;
            gnt_b   = ~owner_b_q & b_req;
        end

        if (gnt_a || gnt_b) begin
            state_d   = ISSUE;
            owner_b_d = gnt_b;
            ptr_b_d   = gnt_b;
            w_d       = gnt_b ? b_w : a_w;
            reg_d     = gnt_b ? b_reg : a_reg;
            data_d    = gnt_b ? b_data : a_data;
            we_d      = first_we(w_d, reg_d);
            busy_d    = 1'b1;
            if (!is_split(w_d, reg_d)) begin
                a_ack_d = ~gnt_b;
                b_ack_d = gnt_b;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            ptr_b_q   <= 1'b1;
            owner_b_q <= 1'b0;
            w_q       <= 1'b0;
            reg_q     <= '0;
            data_q    <= '0;
            we_q      <= '0;
            sel_q     <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_b_q   <= ptr_b_d;
            owner_b_q <= owner_b_d;
            w_q       <= w_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign WE    = we_q;
    assign SEL   = sel_q;
    assign DATA  = data_q;
    assign a_ack = a_ack_q;
    assign b_ack = b_ack_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Bench for reg_write_ctrl: transaction-queue model compared every cycle, a small register
// file fed by WE/SEL/DATA, and directed scenarios with literal expectations.
module tb_reg_write_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        a_req = 1'b0, a_w = 1'b0, b_req = 1'b0, b_w = 1'b0;
    logic [2:0]  a_reg = '0, b_reg = '0;
    logic [15:0] a_data = '0, b_data = '0;
    logic        a_ack, b_ack, SEL, busy;
    logic [11:0] WE;
    logic [15:0] DATA;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    reg_write_ctrl dut (
        .CLK(CLK), .RST(RST),
        .a_req(a_req), .a_w(a_w), .a_reg(a_reg), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_w(b_w), .b_reg(b_reg), .b_data(b_data), .b_ack(b_ack),
        .WE(WE), .SEL(SEL), .DATA(DATA), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register file: AL..BH in rf8[0..7], SP..DI in rf16[0..3].
    logic [7:0]  rf8 [8];
    logic [15:0] rf16[4];
    logic        rf_init = 1'b1;

    always @(posedge CLK) begin
        if (rf_init) begin
            for (int i = 0; i < 8; i++) rf8[i] <= 8'h5A;
            for (int j = 0; j < 4; j++) rf16[j] <= 16'hA5A5;
        end else begin
            for (int i = 0; i < 8; i++)
                if (WE[11-i]) rf8[i] <= SEL ? DATA[15:8] : DATA[7:0];
            for (int j = 0; j < 4; j++)
                if (WE[3-j]) rf16[j] <= DATA;
        end
    end

    // Model: each granted transaction becomes a list of output beats; the head beat is
    // what the outputs must show this cycle, an empty list means idle.
    typedef struct {
        logic [11:0] we;
        logic        sel;
        logic [15:0] data;
        logic        aa;
        logic        ab;
    } beat_t;

    beat_t       mq[$];
    beat_t       ex;
    logic        m_ptr_b = 1'b1, m_owner_b = 1'b0, m_ga, m_gb;
    logic [15:0] m_data = '0;

    task automatic push_txn(input logic own_b, input logic w, input logic [2:0] r, input logic [15:0] d);
        beat_t b1, b2;
        b1.data = d; b1.sel = 1'b0; b1.aa = 1'b0; b1.ab = 1'b0;
        b2.data = d; b2.sel = 1'b1; b2.aa = !own_b; b2.ab = own_b;
        if (w && r < 4) begin
            b1.we = 12'b1 << (11 - r);
            b2.we = 12'b1 << (7 - r);
            mq.push_back(b1);
            mq.push_back(b2);
        end else begin
            b1.we = w ? (12'b1 << (7 - r)) : (12'b1 << (11 - r));
            b1.aa = !own_b;
            b1.ab = own_b;
            mq.push_back(b1);
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            mq.delete();
            m_ptr_b = 1'b1;
            m_data  = '0;
        end else begin
            m_ga = 1'b0;
            m_gb = 1'b0;
            if (mq.size() == 0) begin
                if (a_req && b_req) begin
                    m_ga = m_ptr_b;
                    m_gb = !m_ptr_b;
                end else begin
                    m_ga = a_req;
                    m_gb = b_req;
                end
            end else begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    m_ga = m_owner_b && a_req;
                    m_gb = !m_owner_b && b_req;
                end
            end
            if (m_ga) begin
                push_txn(1'b0, a_w, a_reg, a_data);
                m_owner_b = 1'b0; m_ptr_b = 1'b0; m_data = a_data;
            end
            if (m_gb) begin
                push_txn(1'b1, b_w, b_reg, b_data);
                m_owner_b = 1'b1; m_ptr_b = 1'b1; m_data = b_data;
            end
        end
    end

    logic pa = 1'b0, pb = 1'b0;
    logic log_en = 1'b0;
    int   order[$];

    always @(negedge CLK) begin
        if (mq.size() != 0) begin
            ex = mq[0];
        end else begin
            ex.we = '0; ex.sel = 1'b0; ex.data = m_data; ex.aa = 1'b0; ex.ab = 1'b0;
        end
        chk("WE", WE, ex.we);
        chk("SEL", SEL, ex.sel);
        chk("DATA", DATA, ex.data);
        chk("a_ack", a_ack, ex.aa);
        chk("b_ack", b_ack, ex.ab);
        chk("busy", busy, mq.size() != 0);
        chk("WE_onehot", $countones(WE) <= 1, 1);
        chk("ack_consecutive", (a_ack && pa) || (b_ack && pb), 0);
        pa = a_ack;
        pb = b_ack;
        if (log_en) begin
            if (a_ack) order.push_back(0);
            if (b_ack) order.push_back(1);
        end
    end

    // Requester tasks: call at posedge+1; return the ack cycle (1 = first cycle after
    // the grant edge) and the WE/SEL seen on the ack cycle and the cycle before it.
    task automatic req_a(input logic w, input logic [2:0] r, input logic [15:0] d, input bit hold,
                         output int cyc, output logic [11:0] wp, output logic sp,
                         output logic [11:0] wa, output logic sa, output logic [15:0] da);
        a_req = 1'b1; a_w = w; a_reg = r; a_data = d;
        cyc = -1; wp = '0; sp = 1'b0; wa = '0; sa = 1'b0; da = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (a_ack) begin
                cyc = n; wa = WE; sa = SEL; da = DATA;
                break;
            end
            wp = WE; sp = SEL;
        end
        if (cyc < 0) chk("a_ack_timeout", 1, 0);
        @(posedge CLK); #1;
        if (!hold) a_req = 1'b0;
    endtask

    task automatic req_b(input logic w, input logic [2:0] r, input logic [15:0] d, input bit hold,
                         output int cyc, output logic [11:0] wp, output logic sp,
                         output logic [11:0] wa, output logic sa, output logic [15:0] da);
        b_req = 1'b1; b_w = w; b_reg = r; b_data = d;
        cyc = -1; wp = '0; sp = 1'b0; wa = '0; sa = 1'b0; da = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (b_ack) begin
                cyc = n; wa = WE; sa = SEL; da = DATA;
                break;
            end
            wp = WE; sp = SEL;
        end
        if (cyc < 0) chk("b_ack_timeout", 1, 0);
        @(posedge CLK); #1;
        if (!hold) b_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    int          ca, cb;
    logic [11:0] wpa, waa, wpb, wab;
    logic        spa, saa, spb, sab;
    logic [15:0] daa, dab;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_WE", WE, 12'h000);
        chk("rst_DATA", DATA, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {a_ack, b_ack}, 2'b00);
        RST = 1'b0;
        rf_init = 1'b0;
        @(posedge CLK); #1;

        // Reset during the high half of AX = 0x1234
        a_req = 1'b1; a_w = 1'b1; a_reg = 3'd0; a_data = 16'h1234;
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_lo_WE", WE, 12'h800);
        @(negedge CLK);
        chk("abort_hi_WE", WE, 12'h080);
        #2 RST = 1'b1;
        #1;
        chk("abort_async_WE", WE, 12'h000);
        chk("abort_no_ack", a_ack, 0);
        chk("abort_busy", busy, 0);
        a_req = 1'b0;
        @(posedge CLK);
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        chk("abort_AL", rf8[0], 8'h34);
        chk("abort_AH", rf8[4], 8'h5A);
        @(negedge CLK);
        chk("abort_idle_busy", busy, 0);
        @(posedge CLK); #1;

        // Byte write CH
        req_a(1'b0, 3'd5, 16'h00AB, 1'b0, ca, wpa, spa, waa, saa, daa);
        chk("byte_cyc", ca, 1);
        chk("byte_WE", waa, 12'h040);
        chk("byte_SEL", saa, 0);
        chk("byte_DATA", daa[7:0], 8'hAB);
        chk("byte_CH", rf8[5], 8'hAB);

        // Split word write BX from B
        req_b(1'b1, 3'd3, 16'hBEEF, 1'b0, cb, wpb, spb, wab, sab, dab);
        chk("split_cyc", cb, 2);
        chk("split_lo_WE", wpb, 12'h100);
        chk("split_lo_SEL", spb, 0);
        chk("split_hi_WE", wab, 12'h010);
        chk("split_hi_SEL", sab, 1);
        chk("split_BL", rf8[3], 8'hEF);
        chk("split_BH", rf8[7], 8'hBE);

        // Direct word write SI
        req_a(1'b1, 3'd6, 16'h1357, 1'b0, ca, wpa, spa, waa, saa, daa);
        chk("word_cyc", ca, 1);
        chk("word_WE", waa, 12'h002);
        chk("word_SI", rf16[2], 16'h1357);

        // Contention right after reset: A (DI) wins, B (DX) follows without a gap
        pulse_reset();
        fork
            req_a(1'b1, 3'd7, 16'h1111, 1'b0, ca, wpa, spa, waa, saa, daa);
            req_b(1'b1, 3'd2, 16'h2222, 1'b0, cb, wpb, spb, wab, sab, dab);
        join
        chk("cont_a_cyc", ca, 1);
        chk("cont_a_WE", waa, 12'h001);
        chk("cont_b_cyc", cb, 3);
        chk("cont_b_lo_WE", wpb, 12'h200);
        chk("cont_b_hi_WE", wab, 12'h020);
        chk("cont_b_hi_SEL", sab, 1);
        chk("cont_DI", rf16[3], 16'h1111);
        chk("cont_DL", rf8[2], 8'h22);
        chk("cont_DH", rf8[6], 8'h22);

        // Fairness: both hold req across three byte writes each
        pulse_reset();
        order.delete();
        log_en = 1'b1;
        fork
            begin
                int c; logic [11:0] x1, x2; logic y1, y2; logic [15:0] z;
                for (int i = 0; i < 3; i++)
                    req_a(1'b0, 3'(i), 16'(8'hA0 + i), i < 2, c, x1, y1, x2, y2, z);
            end
            begin
                int c; logic [11:0] x1, x2; logic y1, y2; logic [15:0] z;
                for (int i = 0; i < 3; i++)
                    req_b(1'b0, 3'(4 + i), 16'(8'hB0 + i), i < 2, c, x1, y1, x2, y2, z);
            end
        join
        repeat (2) @(posedge CLK);
        log_en = 1'b0;
        chk("fair_count", order.size(), 6);
        for (int k = 0; k < order.size(); k++)
            chk($sformatf("fair_order_%0d", k), order[k], k % 2);
        chk("fair_DL", rf8[2], 8'hA2);
        chk("fair_DH", rf8[6], 8'hB2);

        repeat (2) @(posedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
